// File: rtl/rom_stream_reader_pkg.sv
// Shared widths, FSM encoding and default frame geometry for the ROM stream reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rom_stream_reader_pkg;

  localparam int ADDR_W       = 19;
  localparam int DATA_W       = 8;
  // Frame pixel count: 10-bit width times 10-bit height.
  localparam int CNT_W        = 20;
  localparam int FRAME_W      = 160;
  localparam int FRAME_H      = 120;
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Unsigned pixel count of a width x height frame.
  function automatic logic [CNT_W-1:0] frame_total(input logic [9:0] w, input logic [9:0] h);
    return CNT_W'(w) * CNT_W'(h);
  endfunction

endpackage

// File: rtl/pixel_skid_fifo.sv
// Register-only FIFO that absorbs ROM data still in flight when the consumer stalls.
// Latency: a write is visible at rd_dat on the cycle after it is accepted.
// Backpressure: writes into a full FIFO are dropped unless a pop happens in the same cycle.
module pixel_skid_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_dat,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_wr, do_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state: push/pop with simultaneous push+pop keeping occupancy unchanged.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_rd    = rd_en && (count_q != '0);
    do_wr    = wr_en && ((count_q != CNT_W'(DEPTH)) || do_rd);
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_rd) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_wr && !do_rd) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_rd && !do_wr) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Storage and pointer registers; reset empties and zeroes the storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_dat = mem_q[rd_ptr_q];
  assign count  = count_q;
  assign empty  = (count_q == '0);

endmodule

// File: rtl/rom_stream_reader.sv
// Streams a width x height frame from a 1-cycle-latency ROM to a valid/ready pixel consumer.
// Latency: first pixel_valid 2 cycles after the edge that samples start; then 1 pixel/cycle.
// Backpressure: reads are throttled so FIFO occupancy plus in-flight reads never exceeds FIFO_DEPTH.
module rom_stream_reader #(
  parameter int ADDR_W     = rom_stream_reader_pkg::ADDR_W,
  parameter int DATA_W     = rom_stream_reader_pkg::DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [9:0]        width_in,
  input  logic [9:0]        height_in,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] pixel_out,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic              busy,
  output logic              done
);

  import rom_stream_reader_pkg::CNT_W;
  import rom_stream_reader_pkg::state_t;
  import rom_stream_reader_pkg::ST_IDLE;
  import rom_stream_reader_pkg::ST_RUN;
  import rom_stream_reader_pkg::ST_DONE;
  import rom_stream_reader_pkg::frame_total;

  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [CNT_W-1:0]  issue_q, issue_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic              inflight_q, inflight_d;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              hs;
  logic [FCNT_W:0]   outstanding;

  // Words already in the FIFO plus the one read whose data lands next edge.
  assign outstanding = {1'b0, fifo_count} + {{FCNT_W{1'b0}}, inflight_q};
  assign pixel_valid = (state_q == ST_RUN) && !fifo_empty;
  assign pixel_out   = fifo_head;
  assign hs          = pixel_valid && pixel_ready;
  assign rom_addr    = ADDR_W'(issue_q);
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign inflight_d  = rom_rd;

  // Frame FSM, read issue throttle and counters.
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    issue_d = issue_q;
    out_d   = out_q;
    rom_rd  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          total_d = frame_total(width_in, height_in);
          issue_d = '0;
          out_d   = '0;
          state_d = (total_d != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        // A pop this cycle frees the slot the new read will land in.
        rom_rd = (issue_q < total_q) &&
                 ((outstanding < (FCNT_W + 1)'(FIFO_DEPTH)) || hs);
        if (rom_rd) begin
          issue_d = issue_q + CNT_W'(1);
        end
        if (hs) begin
          out_d = out_q + CNT_W'(1);
          if (out_d == total_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // start is a level: it must drop before another frame can begin.
        if (!start) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers; reset also drops any read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      total_q    <= '0;
      issue_q    <= '0;
      out_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      issue_q    <= issue_d;
      out_q      <= out_d;
      inflight_q <= inflight_d;
    end
  end

  pixel_skid_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (inflight_q),
    .wr_dat (rom_q),
    .rd_en  (hs),
    .rd_dat (fifo_head),
    .count  (fifo_count),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader: frame table plus reset/backpressure/restart sequences.
// Latency: n/a.
// Backpressure: pixel_ready patterns driven per frame.
module tb_rom_stream_reader;

  import rom_stream_reader_pkg::FRAME_W;
  import rom_stream_reader_pkg::FRAME_H;

  localparam int AW = 19;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [9:0]    width_in, height_in;
  logic [AW-1:0] rom_addr;
  logic          rom_rd;
  logic [DW-1:0] rom_q;
  logic [DW-1:0] pixel_out;
  logic          pixel_valid;
  logic          pixel_ready;
  logic          busy, done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc;

  // Monitor state
  int rd_cnt, hs_cnt, vld_cnt;
  int addr_err, data_err, stab_err, ovf_err;
  int first_valid_cyc, first_hs_cyc, last_hs_cyc;
  bit prev_stall;
  logic [DW-1:0] prev_dat;

  typedef struct {
    int w;
    int h;
    int mode;      // 0 ready, 1 random, 2 alternate, 3 ten-cycle stall
    int exp_pix;
    int exp_first; // cycles from start to first pixel_valid, -1 = never
    int exp_done;  // cycles from start to done, -1 = not checked
  } vec_t;

  vec_t vecs [7];

  rom_stream_reader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .width_in    (width_in),
    .height_in   (height_in),
    .rom_addr    (rom_addr),
    .rom_rd      (rom_rd),
    .rom_q       (rom_q),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rom_f(input int a);
    logic [31:0] v;
    v = a;
    return v[7:0] ^ v[15:8] ^ {5'd0, v[18:16]};
  endfunction

  // ROM model: data one cycle after the read, junk otherwise.
  always @(posedge clk) begin
    if (rom_rd) rom_q <= rom_f(int'(rom_addr));
    else        rom_q <= 8'h5A;
  end

  function automatic logic ready_for(input int mode, input int i);
    case (mode)
      1:       return 1'($urandom_range(0, 1));
      2:       return i[0];
      3:       return !(i >= 40 && i < 50);
      default: return 1'b1;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rom_rd) begin
      if (rom_addr != AW'(rd_cnt)) addr_err++;
      rd_cnt++;
    end
    if (pixel_valid) begin
      vld_cnt++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (prev_stall && (!pixel_valid || pixel_out != prev_dat)) stab_err++;
    if (pixel_valid && pixel_ready) begin
      if (pixel_out != rom_f(hs_cnt)) data_err++;
      if (hs_cnt == 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
      hs_cnt++;
    end
    if (rd_cnt - hs_cnt > 2) ovf_err++;
    prev_stall = pixel_valid && !pixel_ready;
    prev_dat   = pixel_out;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_mon();
    rd_cnt = 0; hs_cnt = 0; vld_cnt = 0;
    addr_err = 0; data_err = 0; stab_err = 0; ovf_err = 0;
    first_valid_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1;
    prev_stall = 1'b0;
  endtask

  task automatic go_idle();
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  // Raise start, scramble the size inputs after capture, wait for done.
  task automatic run_frame(input int w, input int h, input int mode, input int budget,
                           output int done_lat, output int first_lat, output bit to);
    reset_mon();
    width_in    = 10'(w);
    height_in   = 10'(h);
    start       = 1'b1;
    pixel_ready = ready_for(mode, 0);
    start_cyc   = cyc;
    to          = 1'b1;
    done_lat    = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      width_in    = 10'd3;
      height_in   = 10'd2;
      pixel_ready = ready_for(mode, i + 1);
      @(negedge clk); #1;
      if (done) begin
        to       = 1'b0;
        done_lat = cyc - start_cyc;
        break;
      end
    end
    first_lat = (first_valid_cyc < 0) ? -1 : first_valid_cyc - start_cyc;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rom_addr"},    rom_addr, 0);
    check({tag, "_rom_rd"},      rom_rd, 0);
    check({tag, "_pixel_out"},   pixel_out, 0);
    check({tag, "_pixel_valid"}, pixel_valid, 0);
    check({tag, "_busy"},        busy, 0);
    check({tag, "_done"},        done, 0);
  endtask

  initial begin
    int  dl, fl;
    bit  to;
    bit  hit;

    vecs[0] = '{3, 4, 0, 12, 3, 15};
    vecs[1] = '{1, 1, 0, 1, 3, 4};
    vecs[2] = '{0, 5, 0, 0, -1, 1};
    vecs[3] = '{7, 0, 0, 0, -1, 1};
    vecs[4] = '{20, 15, 1, 300, 3, -1};
    vecs[5] = '{9, 5, 2, 45, 3, -1};
    vecs[6] = '{10, 10, 3, 100, 3, -1};

    reset = 1'b1; start = 1'b0; width_in = '0; height_in = '0; pixel_ready = 1'b1;
    reset_mon();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_outputs_zero("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // Frame table
    for (int k = 0; k < 7; k++) begin
      go_idle();
      run_frame(vecs[k].w, vecs[k].h, vecs[k].mode, 2000, dl, fl, to);
      check($sformatf("v%0d_timeout", k),  to, 0);
      check($sformatf("v%0d_hs", k),       hs_cnt, vecs[k].exp_pix);
      check($sformatf("v%0d_rd", k),       rd_cnt, vecs[k].exp_pix);
      check($sformatf("v%0d_data", k),     data_err, 0);
      check($sformatf("v%0d_addr", k),     addr_err, 0);
      check($sformatf("v%0d_ovf", k),      ovf_err, 0);
      check($sformatf("v%0d_stable", k),   stab_err, 0);
      check($sformatf("v%0d_first", k),    fl, vecs[k].exp_first);
      if (vecs[k].exp_done >= 0)
        check($sformatf("v%0d_done_lat", k), dl, vecs[k].exp_done);
    end

    // Full default frame at full rate
    go_idle();
    run_frame(FRAME_W, FRAME_H, 0, 19400, dl, fl, to);
    check("full_timeout", to, 0);
    check("full_hs", hs_cnt, 19200);
    check("full_data", data_err, 0);
    check("full_addr", addr_err, 0);
    check("full_span", last_hs_cyc - first_hs_cyc + 1, 19200);
    check("full_done_edge", start_cyc + dl, last_hs_cyc + 1);
    check("full_busy_after", busy, 0);

    // Start held after done must not restart; dropping it then raising it does
    reset_mon();
    repeat (20) begin @(posedge clk); #1; end
    @(negedge clk); #1;
    check("hold_rd", rd_cnt, 0);
    check("hold_vld", vld_cnt, 0);
    check("hold_done", done, 1);
    go_idle();
    check("idle_done", done, 0);
    run_frame(4, 3, 0, 200, dl, fl, to);
    check("restart_timeout", to, 0);
    check("restart_hs", hs_cnt, 12);
    check("restart_addr", addr_err, 0);
    check("restart_data", data_err, 0);
    check("restart_done_lat", dl, 15);

    // Reset in the middle of a frame
    go_idle();
    reset_mon();
    width_in = 10'(FRAME_W); height_in = 10'(FRAME_H); start = 1'b1; pixel_ready = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      @(negedge clk); #1;
      if (hs_cnt >= 5000) begin hit = 1'b1; break; end
    end
    check("mid_reached", hit, 1);
    check("mid_busy", busy, 1);
    check("mid_done", done, 0);
    check("mid_data", data_err, 0);
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); #1;
    check_outputs_zero("midrst");
    reset = 1'b0;
    @(posedge clk); #1;
    run_frame(8, 4, 0, 200, dl, fl, to);
    check("post_timeout", to, 0);
    check("post_hs", hs_cnt, 32);
    check("post_addr", addr_err, 0);
    check("post_data", data_err, 0);
    check("post_first", fl, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
